// File: rtl/mat_bram_loader.sv
// Stream-to-dual-port BRAM loader: pairs consecutive words into one A/B write per two beats.
// Optional s_last checking is enabled by defining LOADER_LAST_CHECK_EN.
module mat_bram_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 8,
    parameter int ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  enb,
    output logic                  web,
    output logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dinb,
    output logic                  busy,
    output logic                  load_done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    ena_q, ena_d;
    logic                    enb_q, enb_d;
    logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
    logic [ADDR_WIDTH-1:0]   addrb_q, addrb_d;
    logic [DATA_WIDTH-1:0]   dina_q, dina_d;
    logic [DATA_WIDTH-1:0]   dinb_q, dinb_d;
    logic                    done_q, done_d;
    logic                    last_beat;

`ifdef LOADER_LAST_CHECK_EN
    logic                    err_q, err_d;
`else
    logic                    unused_s_last;
    assign unused_s_last = s_last;
`endif

    assign last_beat = (cnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            ena_q   <= 1'b0;
            enb_q   <= 1'b0;
            addra_q <= '0;
            addrb_q <= '0;
            dina_q  <= '0;
            dinb_q  <= '0;
            done_q  <= 1'b0;
`ifdef LOADER_LAST_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ena_q   <= ena_d;
            enb_q   <= enb_d;
            addra_q <= addra_d;
            addrb_q <= addrb_d;
            dina_q  <= dina_d;
            dinb_q  <= dinb_d;
            done_q  <= done_d;
`ifdef LOADER_LAST_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ena_d   = 1'b0;
        enb_d   = 1'b0;
        addra_d = addra_q;
        addrb_d = addrb_q;
        dina_d  = dina_q;
        dinb_d  = dinb_q;
        done_d  = 1'b0;
`ifdef LOADER_LAST_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    cnt_d   = '0;
                    state_d = RECV;
`ifdef LOADER_LAST_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            RECV: begin
                if (s_valid) begin
                    if (cnt_q[0]) begin
                        // Odd beat completes the pair started by the held even word.
                        ena_d   = 1'b1;
                        enb_d   = 1'b1;
                        addra_d = cnt_q - ADDR_WIDTH'(1);
                        addrb_d = cnt_q;
                        dina_d  = hold_q;
                        dinb_d  = s_data;
                    end else if (last_beat) begin
                        ena_d   = 1'b1;
                        addra_d = cnt_q;
                        dina_d  = s_data;
                    end else begin
                        hold_d  = s_data;
                    end
`ifdef LOADER_LAST_CHECK_EN
                    if (s_last != last_beat) begin
                        err_d = 1'b1;
                    end
`endif
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready   = (state_q == RECV);
    assign busy      = (state_q != IDLE);
    assign ena       = ena_q;
    assign wea       = ena_q;
    assign enb       = enb_q;
    assign web       = enb_q;
    assign addra     = addra_q;
    assign addrb     = addrb_q;
    assign dina      = dina_q;
    assign dinb      = dinb_q;
    assign load_done = done_q;
`ifdef LOADER_LAST_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
